// File: rtl/fixed_point_divider_seq.sv
// -----------------------------------------------------------------------------
// fixed_point_divider_seq
//
// Sequential signed fixed-point divider, q = a / b, with operands and result in
// the same Q(WIDTH-FRAC).FRAC two's-complement format. The magnitude quotient
// comes from a non-restoring add/subtract loop that produces one bit per clock.
// Sign and saturation are applied at the end. Results that do not fit, and
// divide-by-zero, saturate to the format limits and raise overflowFlag.
//
// Sequence: IDLE -> PREP (1) -> ITER (N = WIDTH+FRAC) -> FIX (1) -> IDLE.
// done pulses N+2 cycles after start is sampled.
//
// Optional feature, macro FXDIV_ROUND_NEAREST_EN:
//   When defined, ITER runs one extra cycle to produce a guard bit. The
//   magnitude is rounded half away from zero before sign and saturation are
//   applied, and latency becomes N+3. When undefined, the result is truncated
//   toward zero.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE
//   a            in   [WIDTH] dividend, signed fixed-point
//   b            in   [WIDTH] divisor, signed fixed-point
//   busy         out  high from the cycle after start is accepted until done
//   done         out  one-cycle pulse; results are valid from this cycle on
//   quotient     out  [WIDTH] signed result, held until the next accepted start
//   overflowFlag out  result saturated (includes divide-by-zero)
//   divByZero    out  b was zero
// -----------------------------------------------------------------------------
module fixed_point_divider_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             overflowFlag,
    output logic             divByZero
);

    localparam int N = WIDTH + FRAC;
`ifdef FXDIV_ROUND_NEAREST_EN
    localparam int NI = N + 1;      // one extra iteration for the guard bit
`else
    localparam int NI = N;
`endif
    localparam int CW = $clog2(NI + 1);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    // Largest magnitudes that still fit for a positive or negative result.
    localparam logic [N:0] POS_LIM = (N+1)'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [N:0] NEG_LIM = (N+1)'(64'd1 << (WIDTH-1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX
    } state_t;

    state_t state, state_nx;

    logic             sign_r;     // sign of the final result
    logic             a_neg_r;    // dividend sign, picks the divide-by-zero limit
    logic [WIDTH-1:0] mag_a;      // |a|; most-negative a fits as unsigned
    logic [WIDTH-1:0] mag_b;      // |b|
    logic [NI-1:0]    dvd;        // dividend bits, shifted out MSB-first
    logic [WIDTH:0]   rem;        // partial remainder, two's complement
    logic [NI-1:0]    qmag;       // quotient magnitude, built LSB-last
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH+1:0] rem_sh, rem_nx, b_ext;
    logic [N:0]       q_full;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] fix_q;
    logic             fix_ovf, fix_dz;

    assign abs_a = a[WIDTH-1] ? ('0 - a) : a;
    assign abs_b = b[WIDTH-1] ? ('0 - b) : b;

    // One non-restoring step. 2*rem+bit can reach twice |b|, so the step is
    // done one bit wider than the stored remainder. The result always fits
    // back into WIDTH+1 bits.
    assign b_ext  = {2'b00, mag_b};
    assign rem_sh = {rem, dvd[NI-1]};
    assign rem_nx = rem[WIDTH] ? (rem_sh + b_ext) : (rem_sh - b_ext);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking, so all registers
            // update together from values sampled before the edge.
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: the default assignment comes first, so every path drives
        // state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_PREP;
            S_PREP:  state_nx = S_ITER;
            S_ITER:  if (cnt == '0) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Final sign, rounding and saturation
    // -------------------------------------------------------------------------
    always_comb begin
        q_full  = '0;
        fix_q   = '0;
        fix_ovf = 1'b0;
        fix_dz  = 1'b0;
`ifdef FXDIV_ROUND_NEAREST_EN
        // The LSB is the guard bit (one position below the result LSB).
        // Adding it rounds half away from zero in magnitude.
        q_full = {1'b0, qmag[NI-1:1]} + (N+1)'(qmag[0]);
`else
        q_full = {1'b0, qmag};
`endif
        q_w = q_full[WIDTH-1:0];

        if (mag_b == '0) begin
            fix_dz  = 1'b1;
            fix_ovf = 1'b1;
            fix_q   = a_neg_r ? MIN_NEG : MAX_POS;
        end else if (!sign_r && (q_full > POS_LIM)) begin
            fix_ovf = 1'b1;
            fix_q   = MAX_POS;
        end else if (sign_r && (q_full > NEG_LIM)) begin
            fix_ovf = 1'b1;
            fix_q   = MIN_NEG;
        end else begin
            fix_q = sign_r ? ('0 - q_w) : q_w;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the working ones, is cleared.
            // A reset in the middle of an operation leaves no stale state behind.
            sign_r       <= 1'b0;
            a_neg_r      <= 1'b0;
            mag_a        <= '0;
            mag_b        <= '0;
            dvd          <= '0;
            rem          <= '0;
            qmag         <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            overflowFlag <= 1'b0;
            divByZero    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sign_r       <= a[WIDTH-1] ^ b[WIDTH-1];
                        a_neg_r      <= a[WIDTH-1];
                        mag_a        <= abs_a;
                        mag_b        <= abs_b;
                        busy         <= 1'b1;
                        overflowFlag <= 1'b0;
                        divByZero    <= 1'b0;
                    end
                end
                S_PREP: begin
                    // |a| << FRAC, plus a zero guard position when rounding.
                    dvd  <= NI'(mag_a) << (NI - WIDTH);
                    rem  <= '0;
                    qmag <= '0;
                    cnt  <= CW'(NI - 1);
                end
                S_ITER: begin
                    rem  <= rem_nx[WIDTH:0];
                    qmag <= {qmag[NI-2:0], ~rem_nx[WIDTH+1]};
                    dvd  <= dvd << 1;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    quotient     <= fix_q;
                    overflowFlag <= fix_ovf;
                    divByZero    <= fix_dz;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
